// File: rtl/decode.sv
// decode: second pipeline stage of the RV32I core.
// Registers each fetched instruction, splits it into register indices, a
// sign-extended immediate and control flags, and holds the result for execute.
// A one-entry skid buffer absorbs an instruction that arrives while execute
// is stalled. i_flush discards the output register and the skid buffer.
// Optional feature macro: DECODE_ILLEGAL_EN (illegal-encoding detection).
// Without it o_illegal is constant 0 and unknown opcodes decode with all
// control flags low.
module decode #(
    parameter int AW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_en,
    input  logic [31:0]   i_inst,
    input  logic          i_inst_valid,
    input  logic [AW-1:0] i_pc,
    input  logic          i_stall,
    input  logic          i_flush,
    output logic          o_busy,
    output logic          o_valid,
    output logic [AW-1:0] o_pc,
    output logic [4:0]    o_rs1,
    output logic [4:0]    o_rs2,
    output logic [4:0]    o_rd,
    output logic [31:0]   o_imm,
    output logic [2:0]    o_fmt,
    output logic [2:0]    o_funct3,
    output logic          o_funct7b5,
    output logic          o_rd_we,
    output logic          o_mem_rd,
    output logic          o_mem_wr,
    output logic          o_branch,
    output logic          o_jump,
    output logic          o_illegal
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Skid buffer state
    logic          skid_full;
    logic [31:0]   skid_inst;
    logic [AW-1:0] skid_pc;

    // Decode source: the buffered instruction is always older than i_inst
    logic [31:0]   src_inst;
    logic [AW-1:0] src_pc;

    // Combinational decode results
    fmt_e        dec_fmt;
    logic [31:0] dec_imm;
    logic        dec_writes;
    logic        dec_rd_we;
    logic        dec_mem_rd;
    logic        dec_mem_wr;
    logic        dec_branch;
    logic        dec_jump;
    logic        dec_illegal;

    // Skid capture: stalled with room, or draining while a new one arrives
    logic capture;

    assign src_inst = skid_full ? skid_inst : i_inst;
    assign src_pc   = skid_full ? skid_pc   : i_pc;
    assign o_busy   = skid_full;
    assign capture  = i_inst_valid && (i_stall ? !skid_full : skid_full);

    // Decode the selected source into format, immediate and control flags
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        dec_fmt     = FMT_R;
        dec_imm     = '0;
        dec_writes  = 1'b0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_branch  = 1'b0;
        dec_jump    = 1'b0;
        dec_illegal = 1'b0;

        case (src_inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                dec_fmt    = FMT_U;
                dec_writes = 1'b1;
            end
            OPC_JAL: begin
                dec_fmt    = FMT_J;
                dec_writes = 1'b1;
                dec_jump   = 1'b1;
            end
            OPC_JALR: begin
                dec_fmt    = FMT_I;
                dec_writes = 1'b1;
                dec_jump   = 1'b1;
            end
            OPC_LOAD: begin
                dec_fmt    = FMT_I;
                dec_writes = 1'b1;
                dec_mem_rd = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_fmt    = FMT_I;
                dec_writes = 1'b1;
            end
            OPC_SYSTEM, OPC_MISC_MEM: begin
                dec_fmt = FMT_I;
            end
            OPC_STORE: begin
                dec_fmt    = FMT_S;
                dec_mem_wr = 1'b1;
            end
            OPC_BRANCH: begin
                dec_fmt    = FMT_B;
                dec_branch = 1'b1;
            end
            OPC_OP: begin
                dec_fmt    = FMT_R;
                dec_writes = 1'b1;
            end
            default: begin
`ifdef DECODE_ILLEGAL_EN
                dec_illegal = 1'b1;
`endif
            end
        endcase

`ifdef DECODE_ILLEGAL_EN
        // Non-32-bit encodings, and OP with a funct7 RV32I does not define
        if (src_inst[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end
        if (src_inst[6:0] == OPC_OP && src_inst[31:25] != 7'h00 && src_inst[31:25] != 7'h20) begin
            dec_illegal = 1'b1;
        end
`endif

        if (dec_illegal) begin
            dec_writes = 1'b0;
            dec_mem_rd = 1'b0;
            dec_mem_wr = 1'b0;
            dec_branch = 1'b0;
            dec_jump   = 1'b0;
        end

        case (dec_fmt)
            FMT_I:   dec_imm = {{20{src_inst[31]}}, src_inst[31:20]};
            FMT_S:   dec_imm = {{20{src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
            FMT_B:   dec_imm = {{19{src_inst[31]}}, src_inst[31], src_inst[7],
                                src_inst[30:25], src_inst[11:8], 1'b0};
            FMT_U:   dec_imm = {src_inst[31:12], 12'h000};
            FMT_J:   dec_imm = {{11{src_inst[31]}}, src_inst[31], src_inst[19:12],
                                src_inst[20], src_inst[30:21], 1'b0};
            default: dec_imm = '0;
        endcase

        // x0 is hardwired to zero, so a write to it is never requested
        dec_rd_we = dec_writes && (src_inst[11:7] != 5'd0);
    end

    // Output register: load on an unstalled enabled cycle, hold otherwise
    always_ff @(posedge i_clk) begin
        if (i_clk_en) begin
            if (i_rst) begin
                // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
                o_valid    <= 1'b0;
                o_pc       <= '0;
                o_rs1      <= '0;
                o_rs2      <= '0;
                o_rd       <= '0;
                o_imm      <= '0;
                o_fmt      <= '0;
                o_funct3   <= '0;
                o_funct7b5 <= 1'b0;
                o_rd_we    <= 1'b0;
                o_mem_rd   <= 1'b0;
                o_mem_wr   <= 1'b0;
                o_branch   <= 1'b0;
                o_jump     <= 1'b0;
                o_illegal  <= 1'b0;
            end else if (i_flush) begin
                o_valid <= 1'b0;
            end else if (!i_stall) begin
                if (skid_full || i_inst_valid) begin
                    o_valid    <= 1'b1;
                    o_pc       <= src_pc;
                    o_rs1      <= src_inst[19:15];
                    o_rs2      <= src_inst[24:20];
                    o_rd       <= src_inst[11:7];
                    o_imm      <= dec_imm;
                    o_fmt      <= dec_fmt;
                    o_funct3   <= src_inst[14:12];
                    o_funct7b5 <= src_inst[30];
                    o_rd_we    <= dec_rd_we;
                    o_mem_rd   <= dec_mem_rd;
                    o_mem_wr   <= dec_mem_wr;
                    o_branch   <= dec_branch;
                    o_jump     <= dec_jump;
                    o_illegal  <= dec_illegal;
                end else begin
                    o_valid <= 1'b0;
                end
            end
        end
    end

    // Skid buffer occupancy: fill while stalled, drain (and maybe refill) when not
    always_ff @(posedge i_clk) begin
        if (i_clk_en) begin
            if (i_rst || i_flush) begin
                skid_full <= 1'b0;
            end else if (i_stall) begin
                if (capture) begin
                    skid_full <= 1'b1;
                end
            end else if (skid_full) begin
                skid_full <= i_inst_valid;
            end
        end
    end

    // Skid payload: only meaningful while skid_full is set
    always_ff @(posedge i_clk) begin
        // NOTE: payload has no reset; skid_full alone decides whether it is used.
        if (i_clk_en && !i_rst && !i_flush && capture) begin
            skid_inst <= i_inst;
            skid_pc   <= i_pc;
        end
    end

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed and randomized bench for decode, checked against a
// queue-based reference model that decodes from the RV32I encoding rules.
// Expectations for o_illegal follow DECODE_ILLEGAL_EN when it is defined.
module tb_decode;

    localparam int AW = 32;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_clk_en;
    logic [31:0]   i_inst;
    logic          i_inst_valid;
    logic [AW-1:0] i_pc;
    logic          i_stall;
    logic          i_flush;
    logic          o_busy;
    logic          o_valid;
    logic [AW-1:0] o_pc;
    logic [4:0]    o_rs1;
    logic [4:0]    o_rs2;
    logic [4:0]    o_rd;
    logic [31:0]   o_imm;
    logic [2:0]    o_fmt;
    logic [2:0]    o_funct3;
    logic          o_funct7b5;
    logic          o_rd_we;
    logic          o_mem_rd;
    logic          o_mem_wr;
    logic          o_branch;
    logic          o_jump;
    logic          o_illegal;

    decode #(.AW(AW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clk_en     (i_clk_en),
        .i_inst       (i_inst),
        .i_inst_valid (i_inst_valid),
        .i_pc         (i_pc),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .o_busy       (o_busy),
        .o_valid      (o_valid),
        .o_pc         (o_pc),
        .o_rs1        (o_rs1),
        .o_rs2        (o_rs2),
        .o_rd         (o_rd),
        .o_imm        (o_imm),
        .o_fmt        (o_fmt),
        .o_funct3     (o_funct3),
        .o_funct7b5   (o_funct7b5),
        .o_rd_we      (o_rd_we),
        .o_mem_rd     (o_mem_rd),
        .o_mem_wr     (o_mem_wr),
        .o_branch     (o_branch),
        .o_jump       (o_jump),
        .o_illegal    (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    rd;
        logic [31:0]   imm;
        logic [2:0]    fmt;
        logic [2:0]    funct3;
        logic          f7b5;
        logic          rd_we;
        logic          mem_rd;
        logic          mem_wr;
        logic          branch;
        logic          jump;
        logic          illegal;
    } exp_t;

    typedef struct {
        logic [31:0]   inst;
        logic [AW-1:0] pc;
    } pend_t;

    int    total = 0;
    int    bad   = 0;
    exp_t  exp_out;
    logic  exp_valid;
    pend_t pend_q[$];

`ifdef DECODE_ILLEGAL_EN
    localparam logic ILLEGAL_EN = 1'b1;
`else
    localparam logic ILLEGAL_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode, written from the RV32I field layout with arithmetic
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [AW-1:0] pc);
        exp_t e;
        logic writes;
        logic known;
        e        = '{default: '0};
        writes   = 1'b0;
        known    = 1'b1;
        e.pc     = pc;
        e.rs1    = w[19:15];
        e.rs2    = w[24:20];
        e.rd     = w[11:7];
        e.funct3 = w[14:12];
        e.f7b5   = w[30];
        case (w[6:0])
            7'b0110111, 7'b0010111: begin e.fmt = 3'd4; writes = 1'b1; end
            7'b1101111:             begin e.fmt = 3'd5; writes = 1'b1; e.jump = 1'b1; end
            7'b1100111:             begin e.fmt = 3'd1; writes = 1'b1; e.jump = 1'b1; end
            7'b0000011:             begin e.fmt = 3'd1; writes = 1'b1; e.mem_rd = 1'b1; end
            7'b0010011:             begin e.fmt = 3'd1; writes = 1'b1; end
            7'b1110011, 7'b0001111: begin e.fmt = 3'd1; end
            7'b0100011:             begin e.fmt = 3'd2; e.mem_wr = 1'b1; end
            7'b1100011:             begin e.fmt = 3'd3; e.branch = 1'b1; end
            7'b0110011:             begin e.fmt = 3'd0; writes = 1'b1; end
            default:                begin e.fmt = 3'd0; known = 1'b0; end
        endcase
        case (e.fmt)
            3'd1: e.imm = 32'($signed(w) >>> 20);
            3'd2: e.imm = 32'(($signed(w) >>> 25) <<< 5) | 32'(w[11:7]);
            3'd3: e.imm = 32'(($signed(w) >>> 31) <<< 12) | (32'(w[7]) << 11)
                        | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            3'd4: e.imm = w & 32'hFFFF_F000;
            3'd5: e.imm = 32'(($signed(w) >>> 31) <<< 20) | (32'(w[19:12]) << 12)
                        | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            default: e.imm = 32'd0;
        endcase
        e.illegal = ILLEGAL_EN && (w[1:0] != 2'b11 || !known ||
                    (w[6:0] == 7'b0110011 && w[31:25] != 7'h00 && w[31:25] != 7'h20));
        if (e.illegal) begin
            writes   = 1'b0;
            e.mem_rd = 1'b0;
            e.mem_wr = 1'b0;
            e.branch = 1'b0;
            e.jump   = 1'b0;
        end
        e.rd_we = writes && (w[11:7] != 5'd0);
        return e;
    endfunction

    // Pipeline model: a FIFO of accepted-but-not-yet-presented instructions
    task automatic model_edge();
        pend_t p;
        if (!i_clk_en) return;
        if (i_rst) begin
            exp_valid = 1'b0;
            exp_out   = '{default: '0};
            pend_q.delete();
        end else if (i_flush) begin
            exp_valid = 1'b0;
            pend_q.delete();
        end else if (!i_stall) begin
            if (pend_q.size() > 0) begin
                p         = pend_q.pop_front();
                exp_out   = ref_decode(p.inst, p.pc);
                exp_valid = 1'b1;
                if (i_inst_valid) pend_q.push_back('{inst: i_inst, pc: i_pc});
            end else if (i_inst_valid) begin
                exp_out   = ref_decode(i_inst, i_pc);
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
        end else if (i_inst_valid && pend_q.size() == 0) begin
            pend_q.push_back('{inst: i_inst, pc: i_pc});
        end
    endtask

    task automatic compare_all();
        check("valid",   32'(o_valid),    32'(exp_valid));
        check("busy",    32'(o_busy),     32'(pend_q.size() != 0));
        check("pc",      32'(o_pc),       32'(exp_out.pc));
        check("rs1",     32'(o_rs1),      32'(exp_out.rs1));
        check("rs2",     32'(o_rs2),      32'(exp_out.rs2));
        check("rd",      32'(o_rd),       32'(exp_out.rd));
        check("imm",     o_imm,           exp_out.imm);
        check("fmt",     32'(o_fmt),      32'(exp_out.fmt));
        check("funct3",  32'(o_funct3),   32'(exp_out.funct3));
        check("f7b5",    32'(o_funct7b5), 32'(exp_out.f7b5));
        check("rd_we",   32'(o_rd_we),    32'(exp_out.rd_we));
        check("mem_rd",  32'(o_mem_rd),   32'(exp_out.mem_rd));
        check("mem_wr",  32'(o_mem_wr),   32'(exp_out.mem_wr));
        check("branch",  32'(o_branch),   32'(exp_out.branch));
        check("jump",    32'(o_jump),     32'(exp_out.jump));
        check("illegal", 32'(o_illegal),  32'(exp_out.illegal));
    endtask

    // One clock: flag protocol misuse, clock the DUT and model, then compare
    task automatic step();
        if (i_clk_en && !i_rst && !i_flush && i_stall && i_inst_valid && pend_q.size() != 0) begin
            bad++;
            $error("FAIL protocol: strobe into full skid buffer observed=1 expected=0");
        end
        @(posedge i_clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic issue(input logic [31:0] w, input logic [AW-1:0] pc);
        i_inst       = w;
        i_pc         = pc;
        i_inst_valid = 1'b1;
        step();
        i_inst_valid = 1'b0;
    endtask

    function automatic logic [6:0] opcode_at(input int k);
        case (k)
            0:       return 7'b0110111;
            1:       return 7'b0010111;
            2:       return 7'b1101111;
            3:       return 7'b1100111;
            4:       return 7'b1100011;
            5:       return 7'b0000011;
            6:       return 7'b0100011;
            7:       return 7'b0010011;
            8:       return 7'b0110011;
            9:       return 7'b0001111;
            default: return 7'b1110011;
        endcase
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom();
        if ($urandom_range(0, 9) == 0) return w;
        w[6:0] = opcode_at($urandom_range(0, 10));
        if (w[6:0] == 7'b0110011) begin
            case ($urandom_range(0, 2))
                0:       w[31:25] = 7'h00;
                1:       w[31:25] = 7'h20;
                default: ;
            endcase
        end
        return w;
    endfunction

    initial begin
        exp_valid    = 1'b0;
        exp_out      = '{default: '0};
        i_rst        = 1'b1;
        i_clk_en     = 1'b1;
        i_inst       = '0;
        i_inst_valid = 1'b0;
        i_pc         = '0;
        i_stall      = 1'b0;
        i_flush      = 1'b0;

        // Reset state
        step();
        step();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_imm",   o_imm,        32'd0);
        i_rst = 1'b0;

        // addi x1,x0,5
        issue(32'h0050_0093, 32'h0000_0000);
        check("addi_valid", 32'(o_valid), 32'd1);
        check("addi_rd",    32'(o_rd),    32'd1);
        check("addi_rs1",   32'(o_rs1),   32'd0);
        check("addi_imm",   o_imm,        32'd5);
        check("addi_fmt",   32'(o_fmt),   32'd1);
        check("addi_we",    32'(o_rd_we), 32'd1);

        // sw x2,-4(x1)
        issue(32'hFE20_AE23, 32'h0000_0004);
        check("sw_rs1", 32'(o_rs1),    32'd1);
        check("sw_rs2", 32'(o_rs2),    32'd2);
        check("sw_imm", o_imm,         32'hFFFF_FFFC);
        check("sw_fmt", 32'(o_fmt),    32'd2);
        check("sw_wr",  32'(o_mem_wr), 32'd1);
        check("sw_we",  32'(o_rd_we),  32'd0);

        // lui x5,0x12345
        issue(32'h1234_52B7, 32'h0000_0008);
        check("lui_imm", o_imm,       32'h1234_5000);
        check("lui_rd",  32'(o_rd),   32'd5);
        check("lui_fmt", 32'(o_fmt),  32'd4);

        // jal x0,0
        issue(32'h0000_006F, 32'h0000_000C);
        check("jal_jump", 32'(o_jump),  32'd1);
        check("jal_we",   32'(o_rd_we), 32'd0);

        // Stall with a strobe: outputs hold, skid fills
        i_stall = 1'b1;
        issue(32'h00A0_0113, 32'h0000_0100);
        check("stall_pc",   32'(o_pc),   32'h0000_000C);
        check("stall_busy", 32'(o_busy), 32'd1);
        step();
        check("stall_hold", 32'(o_jump), 32'd1);
        i_stall = 1'b0;
        step();
        check("drain_pc",   32'(o_pc),   32'h0000_0100);
        check("drain_rd",   32'(o_rd),   32'd2);
        check("drain_busy", 32'(o_busy), 32'd0);

        // Flush with a full skid and a simultaneous strobe
        i_stall = 1'b1;
        issue(32'h0030_0193, 32'h0000_0200);
        i_stall      = 1'b0;
        i_flush      = 1'b1;
        i_inst       = 32'h0040_0213;
        i_pc         = 32'h0000_0204;
        i_inst_valid = 1'b1;
        step();
        i_flush      = 1'b0;
        i_inst_valid = 1'b0;
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_busy",  32'(o_busy),  32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("flush_gone", 32'(o_valid), 32'd0);
        end

        // All-zero word
        issue(32'h0000_0000, 32'h0000_0300);
        check("zero_valid",   32'(o_valid),   32'd1);
        check("zero_illegal", 32'(o_illegal), 32'(ILLEGAL_EN));
        check("zero_flags",   32'({o_rd_we, o_mem_rd, o_mem_wr, o_branch, o_jump}), 32'd0);

        // Reset with a full skid buffer
        i_stall = 1'b1;
        issue(32'h0050_0093, 32'h0000_0400);
        i_rst = 1'b1;
        step();
        i_rst   = 1'b0;
        i_stall = 1'b0;
        check("rst_full_busy",  32'(o_busy),  32'd0);
        check("rst_full_valid", 32'(o_valid), 32'd0);
        step();
        check("rst_full_gone",  32'(o_valid), 32'd0);

        // Clock enable low freezes everything, including reset
        issue(32'h0050_0093, 32'h0000_0500);
        i_clk_en = 1'b0;
        i_rst    = 1'b1;
        issue(32'h1234_52B7, 32'h0000_0504);
        check("cen_valid", 32'(o_valid), 32'd1);
        check("cen_pc",    32'(o_pc),    32'h0000_0500);
        i_clk_en = 1'b1;
        i_rst    = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            i_clk_en     = ($urandom_range(0, 9) != 0);
            i_rst        = ($urandom_range(0, 99) == 0);
            i_flush      = ($urandom_range(0, 19) == 0);
            i_stall      = ($urandom_range(0, 2) == 0);
            i_inst_valid = ($urandom_range(0, 1) == 1);
            if (i_stall && pend_q.size() != 0) i_inst_valid = 1'b0;
            i_inst = rand_inst();
            i_pc   = $urandom();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
